// File: rtl/aclock_seg_display.sv
// aclock_seg_display
// ------------------
// Display stage for the alarm-clock core. Scans six BCD digits onto a
// common-anode 7-segment panel, one digit at a time.
//
// Features:
//   - Frame-coherent snapshot of the six digits. They are captured at the
//     start of every frame, so a frame never mixes two times.
//   - Colon shown via the decimal points of digits 2 and 4.
//   - Optional blanking of a leading zero in the hour-tens digit.
//   - Whole-panel blinking while Alarm is high.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   H_out1..S_out0  BCD time digits (H_out1 is 2 bits wide)
//   Alarm         blink the panel while high
//   disp_en       0 = all anodes off; scanning keeps running underneath
//   lzb_en        1 = blank the hour-tens digit when it reads 0
//   an            active-low anode selects; an[0] = S_out0 ... an[5] = H_out1
//   seg           active-low segments {g,f,e,d,c,b,a}
//   dp            active-low decimal point
//
// Outputs are registered. They reflect the digit_sel/div_cnt state in
// effect on the edge that loads them.
module aclock_seg_display #(
    parameter int SCAN_DIV  = 2,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic [3:0] S_out1,
    input  logic [3:0] S_out0,
    input  logic       Alarm,
    input  logic       disp_en,
    input  logic       lzb_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        SHOW   = 2'd1,
        HIDE   = 2'd2
    } blink_state_t;

    // Scan state
    logic [DW-1:0] div_cnt;
    logic [2:0]    digit_sel;
    logic          capture;

    // Digit bundle: {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}
    logic [21:0] live;
    logic [21:0] shadow;
    logic [21:0] src;

    // Blink FSM
    blink_state_t blink_state, blink_state_nx;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          blink_ph;

    // Output register inputs
    logic [3:0] v;
    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic       blank;

    assign live    = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    assign capture = (div_cnt == '0) && (digit_sel == 3'd0);

    // ------------------------------------------------------------------
    // Scan counter and snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_sel <= 3'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            digit_sel <= (digit_sel == 3'd5) ? 3'd0 : digit_sel + 3'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (capture) begin
            shadow <= live;
        end
    end

    // ------------------------------------------------------------------
    // Blink FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_state <= STEADY;
            blink_cnt   <= '0;
        end else begin
            blink_state <= blink_state_nx;
            blink_cnt   <= blink_cnt_nx;
        end
    end

    // The edge that first sees Alarm high, taken while still STEADY, is
    // treated as count 0 of the SHOW phase. That edge already shows the
    // panel, so the first visible phase lasts exactly BLINK_DIV output
    // cycles, the same length as every later phase.
    always_comb begin
        logic          cur_hide;
        logic [BW-1:0] cur_cnt;
        blink_state_nx = STEADY;
        blink_cnt_nx   = '0;
        cur_hide       = (blink_state == HIDE);
        cur_cnt        = (blink_state == STEADY) ? '0 : blink_cnt;
        if (Alarm) begin
            if (cur_cnt == BLINK_LAST) begin
                blink_state_nx = cur_hide ? SHOW : HIDE;
                blink_cnt_nx   = '0;
            end else begin
                blink_state_nx = cur_hide ? HIDE : SHOW;
                blink_cnt_nx   = cur_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        blink_ph = (blink_state == HIDE);
    end

    // ------------------------------------------------------------------
    // Digit select, decode and output register
    // ------------------------------------------------------------------
    function automatic logic [6:0] decode7(input logic [3:0] d);
        case (d)
            4'd0:    decode7 = 7'b1000000;
            4'd1:    decode7 = 7'b1111001;
            4'd2:    decode7 = 7'b0100100;
            4'd3:    decode7 = 7'b0110000;
            4'd4:    decode7 = 7'b0011001;
            4'd5:    decode7 = 7'b0010010;
            4'd6:    decode7 = 7'b0000010;
            4'd7:    decode7 = 7'b1111000;
            4'd8:    decode7 = 7'b0000000;
            4'd9:    decode7 = 7'b0010000;
            default: decode7 = 7'b1111111;
        endcase
    endfunction

    // The capture edge reads the live inputs so that digit 0 of the new
    // frame matches what is being loaded into the shadow.
    assign src = capture ? live : shadow;

    always_comb begin
        case (digit_sel)
            3'd0:    v = src[3:0];
            3'd1:    v = src[7:4];
            3'd2:    v = src[11:8];
            3'd3:    v = src[15:12];
            3'd4:    v = src[19:16];
            3'd5:    v = {2'b00, src[21:20]};
            default: v = 4'd0;
        endcase
    end

    assign blank = !disp_en || (Alarm && blink_ph);

    always_comb begin
        an_d  = ~(6'b000001 << digit_sel);
        seg_d = decode7(v);
        dp_d  = !((digit_sel == 3'd2) || (digit_sel == 3'd4));
        if ((digit_sel == 3'd5) && lzb_en && (v == 4'd0)) begin
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
        if (blank) begin
            an_d  = 6'b111111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
